ysyx_22050598_pipe_stage: RTL and testbench

- Generic, parametrised inter-stage pipeline register. It is the successor to the fixed-field stall/flush stage registers between IF/ID/EX/MEM/WB.
- Replaces the global stall with a per-stage valid/ready handshake and a 2-entry skid buffer, so in_ready is fully registered.
- Keeps synchronous flush-to-bubble, and adds a data-enable lane for wide, rarely-used fields (PC, immediates) to cut toggle power.
- Instantiated once per pipeline boundary; payload is a packed bus assembled by the caller.

---
 rtl/ysyx_22050598_pipe_pkg.sv | 21 ++
 rtl/ysyx_22050598_pipe_stage_if.sv | 13 +
 rtl/ysyx_22050598_pipe_ent.sv | 69 ++++++
 rtl/ysyx_22050598_sirv_gnrl_dfflr.sv | 23 ++
 rtl/ysyx_22050598_pipe_stage.sv | 143 ++++++++++++++
 tb/tb_ysyx_22050598_pipe_stage.sv | 257 +++++++++++++++++++++++++
 6 files changed

// File: rtl/ysyx_22050598_pipe_pkg.sv
// Shared definitions for the inter-stage pipeline register: FSM encoding,
// payload field offsets and per-boundary bubble constants.
package ysyx_22050598_pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } pipe_st_e;

   localparam int PL_INST_LSB = 0;
   localparam int PL_OPT_LSB  = 32;

   localparam logic [31:0] NOP_INST   = 32'h0000_0013;
   localparam logic [9:0]  OPT_BUBBLE = 10'b10_0000_0000;

   // ID/EX bubble: op_type bubble code over a NOP instruction word
   localparam logic [63:0] ID_EX_BUBBLE = (64'(OPT_BUBBLE) << PL_OPT_LSB)
                                        | (64'(NOP_INST)   << PL_INST_LSB);

endpackage

// File: rtl/ysyx_22050598_pipe_stage_if.sv
// Valid/ready channel with payload and gated-lane enable, used on both
// sides of a pipeline boundary register.
interface ysyx_22050598_pipe_stage_if #(
   parameter int DW = 64
) ();
   logic          valid;
   logic          ready;
   logic          gate_en;
   logic [DW-1:0] data;

   modport master (output valid, output data, output gate_en, input ready);
   modport slave  (input valid, input data, input gate_en, output ready);
endinterface

// File: rtl/ysyx_22050598_pipe_ent.sv
// Single pipeline entry: valid flag, payload and stored gate enable.
// clr (flush) beats ld beats rls; GATED entries only load the low GW bits when gate_en_i.
module ysyx_22050598_pipe_ent #(
   parameter int            DW     = 64,
   parameter int            GW     = 0,
   parameter bit            GATED  = 1'b0,
   parameter logic [DW-1:0] BUBBLE = '0
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clr_i,
   input  logic          ld_i,
   input  logic          rls_i,
   input  logic          gate_en_i,
   input  logic [DW-1:0] data_i,
   output logic          vld_o,
   output logic          gate_en_o,
   output logic [DW-1:0] data_o
);
   ysyx_22050598_sirv_gnrl_dfflr #(.DW(1), .INIT(1'b0)) u_vld (
      .clk_i, .rst_i,
      .lden_i (clr_i | ld_i | rls_i),
      .d_i    (ld_i & ~clr_i),
      .q_o    (vld_o)
   );

   ysyx_22050598_sirv_gnrl_dfflr #(.DW(1), .INIT(1'b0)) u_gate (
      .clk_i, .rst_i,
      .lden_i (clr_i | ld_i),
      .d_i    (gate_en_i & ~clr_i),
      .q_o    (gate_en_o)
   );

   generate
      if (GATED && (GW > 0)) begin : g_gated
         logic [GW-1:0] lo_d;
         assign lo_d = clr_i ? BUBBLE[GW-1:0] : data_i[GW-1:0];

         ysyx_22050598_sirv_gnrl_dfflr #(.DW(GW), .INIT(BUBBLE[GW-1:0])) u_lo (
            .clk_i, .rst_i,
            .lden_i (clr_i | (ld_i & gate_en_i)),
            .d_i    (lo_d),
            .q_o    (data_o[GW-1:0])
         );

         if (GW < DW) begin : g_hi
            logic [DW-GW-1:0] hi_d;
            assign hi_d = clr_i ? BUBBLE[DW-1:GW] : data_i[DW-1:GW];

            ysyx_22050598_sirv_gnrl_dfflr #(.DW(DW-GW), .INIT(BUBBLE[DW-1:GW])) u_hi (
               .clk_i, .rst_i,
               .lden_i (clr_i | ld_i),
               .d_i    (hi_d),
               .q_o    (data_o[DW-1:GW])
            );
         end
      end else begin : g_flat
         logic [DW-1:0] all_d;
         assign all_d = clr_i ? BUBBLE : data_i;

         ysyx_22050598_sirv_gnrl_dfflr #(.DW(DW), .INIT(BUBBLE)) u_all (
            .clk_i, .rst_i,
            .lden_i (clr_i | ld_i),
            .d_i    (all_d),
            .q_o    (data_o)
         );
      end
   endgenerate
endmodule

// File: rtl/ysyx_22050598_sirv_gnrl_dfflr.sv
// Load-enabled register cell with synchronous active-high reset to INIT.
module ysyx_22050598_sirv_gnrl_dfflr #(
   parameter int            DW   = 1,
   parameter logic [DW-1:0] INIT = '0
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          lden_i,
   input  logic [DW-1:0] d_i,
   output logic [DW-1:0] q_o
);
   logic [DW-1:0] qout_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         qout_q <= INIT;
      end else if (lden_i) begin
         qout_q <= d_i;
      end
   end

   assign q_o = qout_q;
endmodule

// File: rtl/ysyx_22050598_pipe_stage.sv
// Pipeline boundary register with valid/ready handshake, 2-entry skid buffer,
// flush-to-bubble and gated low lane. Perf counters under YSYX_22050598_PIPE_PERF_EN.
//
// state    | meaning
// ST_EMPTY | no entries held
// ST_ONE   | main entry valid, skid empty
// ST_TWO   | main and skid valid, upstream stalled
module ysyx_22050598_pipe_stage
   import ysyx_22050598_pipe_pkg::*;
#(
   parameter int            DW     = 64,
   parameter int            GW     = 0,
   parameter logic [DW-1:0] BUBBLE = '0,
   parameter int            CW     = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic flush_i,
`ifdef YSYX_22050598_PIPE_PERF_EN
   output logic [CW-1:0] stall_cnt_o,
   output logic [CW-1:0] bubble_cnt_o,
`endif
   ysyx_22050598_pipe_stage_if.slave  up_if,
   ysyx_22050598_pipe_stage_if.master dn_if
);
   pipe_st_e      state_q, state_d;
   logic          acc, rel;
   logic          main_ld, main_rls, skid_ld, skid_rls, main_from_skid;
   logic          main_vld, skid_vld, skid_gate;
   logic          main_gate_d, unused_main_gate;
   logic [DW-1:0] main_data, skid_data, main_data_d;

   assign acc = up_if.valid & ~skid_vld;
   assign rel = main_vld & dn_if.ready;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: if (acc) state_d = ST_ONE;
            ST_ONE: begin
               if (acc & ~rel)      state_d = ST_TWO;
               else if (~acc & rel) state_d = ST_EMPTY;
            end
            ST_TWO:   if (rel) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
         endcase
      end
   end

   // flush is applied inside the entries as a clear that overrides these loads
   always_comb begin
      main_ld        = 1'b0;
      main_rls       = 1'b0;
      skid_ld        = 1'b0;
      skid_rls       = 1'b0;
      main_from_skid = 1'b0;
      case (state_q)
         ST_EMPTY: main_ld = acc;
         ST_ONE: begin
            main_ld  = acc & rel;
            skid_ld  = acc & ~rel;
            main_rls = ~acc & rel;
         end
         ST_TWO: begin
            main_ld        = rel;
            skid_rls       = rel;
            main_from_skid = 1'b1;
         end
         default: ;
      endcase
   end

   assign main_data_d = main_from_skid ? skid_data : up_if.data;
   assign main_gate_d = main_from_skid ? skid_gate : up_if.gate_en;

   ysyx_22050598_pipe_ent #(.DW(DW), .GW(GW), .GATED(1'b1), .BUBBLE(BUBBLE)) u_main (
      .clk_i, .rst_i,
      .clr_i     (flush_i),
      .ld_i      (main_ld),
      .rls_i     (main_rls),
      .gate_en_i (main_gate_d),
      .data_i    (main_data_d),
      .vld_o     (main_vld),
      .gate_en_o (unused_main_gate),
      .data_o    (main_data)
   );

   ysyx_22050598_pipe_ent #(.DW(DW), .GW(GW), .GATED(1'b0), .BUBBLE(BUBBLE)) u_skid (
      .clk_i, .rst_i,
      .clr_i     (flush_i),
      .ld_i      (skid_ld),
      .rls_i     (skid_rls),
      .gate_en_i (up_if.gate_en),
      .data_i    (up_if.data),
      .vld_o     (skid_vld),
      .gate_en_o (skid_gate),
      .data_o    (skid_data)
   );

   assign up_if.ready = ~skid_vld;
   assign dn_if.valid = main_vld;
   assign dn_if.data  = main_data;

`ifdef YSYX_22050598_PIPE_PERF_EN
   logic [CW-1:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;

   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (main_vld & ~dn_if.ready & ~(&stall_cnt_q))
         stall_cnt_d = stall_cnt_q + CW'(1);
      if (~main_vld & dn_if.ready & ~(&bubble_cnt_q))
         bubble_cnt_d = bubble_cnt_q + CW'(1);
   end

   // counters survive flush; only reset clears them
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign stall_cnt_o  = stall_cnt_q;
   assign bubble_cnt_o = bubble_cnt_q;
`else
   localparam int unused_cw = CW;
`endif
endmodule

// File: tb/tb_ysyx_22050598_pipe_stage.sv
// Bench for the pipeline stage: two instances (GW=0 and GW=32 with a
// non-zero bubble) share stimulus and are checked against a queue model.
module tb_ysyx_22050598_pipe_stage;
   import ysyx_22050598_pipe_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_gate = 1'b0;
   logic        out_ready = 1'b0;
   logic [63:0] in_data = '0;

   int tot = 0;
   int bad = 0;

   always #5 clk = ~clk;

   ysyx_22050598_pipe_stage_if #(.DW(64)) up_a ();
   ysyx_22050598_pipe_stage_if #(.DW(64)) dn_a ();
   ysyx_22050598_pipe_stage_if #(.DW(64)) up_b ();
   ysyx_22050598_pipe_stage_if #(.DW(64)) dn_b ();

   assign up_a.valid   = in_valid;
   assign up_a.data    = in_data;
   assign up_a.gate_en = in_gate;
   assign dn_a.ready   = out_ready;
   assign up_b.valid   = in_valid;
   assign up_b.data    = in_data;
   assign up_b.gate_en = in_gate;
   assign dn_b.ready   = out_ready;

`ifdef YSYX_22050598_PIPE_PERF_EN
   logic [15:0] stall_a, bubble_a;
   logic [3:0]  stall_b, bubble_b;
`endif

   ysyx_22050598_pipe_stage #(.DW(64), .GW(0)) dut_a (
      .clk_i   (clk),
      .rst_i   (rst),
      .flush_i (flush),
`ifdef YSYX_22050598_PIPE_PERF_EN
      .stall_cnt_o  (stall_a),
      .bubble_cnt_o (bubble_a),
`endif
      .up_if   (up_a),
      .dn_if   (dn_a)
   );

   ysyx_22050598_pipe_stage #(.DW(64), .GW(32), .BUBBLE(ID_EX_BUBBLE), .CW(4)) dut_b (
      .clk_i   (clk),
      .rst_i   (rst),
      .flush_i (flush),
`ifdef YSYX_22050598_PIPE_PERF_EN
      .stall_cnt_o  (stall_b),
      .bubble_cnt_o (bubble_b),
`endif
      .up_if   (up_b),
      .dn_if   (dn_b)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tot++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // reference model: FIFO of at most two entries holding the payload each
   // instance must present; gated lane resolved at accept time in FIFO order
   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
   } ent_t;

   ent_t        q[$];
   logic [63:0] bub_b = 64'h0000_0200_0000_0013;
   logic [63:0] last_a, last_b;
   logic [31:0] lane_b;
   int          stall_n, bubble_n;
   bit          known = 1'b0;

   always @(posedge clk) begin : model
      bit   m_acc, m_rel;
      ent_t e;
      m_rel = (q.size() > 0) && out_ready;
      m_acc = in_valid && (q.size() < 2);
      if (rst) begin
         q.delete();
         last_a   = '0;
         last_b   = bub_b;
         lane_b   = bub_b[31:0];
         stall_n  = 0;
         bubble_n = 0;
         known    = 1'b1;
      end else begin
         if (q.size() > 0 && !out_ready) stall_n++;
         if (q.size() == 0 && out_ready) bubble_n++;
         if (flush) begin
            q.delete();
            last_a = '0;
            last_b = bub_b;
            lane_b = bub_b[31:0];
         end else begin
            if (m_rel) begin
               e = q.pop_front();
               last_a = e.a;
               last_b = e.b;
            end
            if (m_acc) begin
               if (in_gate) lane_b = in_data[31:0];
               e.a = in_data;
               e.b = {in_data[63:32], lane_b};
               q.push_back(e);
            end
         end
      end
   end

   always @(negedge clk) begin : compare
      if (known) begin
         chk("in_ready_a",  up_a.ready,  q.size() < 2);
         chk("in_ready_b",  up_b.ready,  q.size() < 2);
         chk("out_valid_a", dn_a.valid, q.size() > 0);
         chk("out_valid_b", dn_b.valid, q.size() > 0);
         chk("out_data_a",  dn_a.data,  (q.size() > 0) ? q[0].a : last_a);
         chk("out_data_b",  dn_b.data,  (q.size() > 0) ? q[0].b : last_b);
         chk("skid_implies_main_a", dut_a.skid_vld & ~dut_a.main_vld, 1'b0);
         chk("skid_implies_main_b", dut_b.skid_vld & ~dut_b.main_vld, 1'b0);
`ifdef YSYX_22050598_PIPE_PERF_EN
         chk("stall_a",  stall_a,  (stall_n  > 65535) ? 65535 : stall_n);
         chk("bubble_a", bubble_a, (bubble_n > 65535) ? 65535 : bubble_n);
         chk("stall_b",  stall_b,  (stall_n  > 15) ? 15 : stall_n);
         chk("bubble_b", bubble_b, (bubble_n > 15) ? 15 : bubble_n);
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [63:0] d, input logic g);
      in_valid = v;
      in_data  = d;
      in_gate  = g;
   endtask

   initial begin
      tick();
      tick();
      rst = 1'b0;
      chk("rst_in_ready",  up_a.ready, 1'b1);
      chk("rst_out_valid", dn_a.valid, 1'b0);
      chk("rst_data_a",    dn_a.data,  64'h0);
      chk("rst_data_b",    dn_b.data,  64'h0000_0200_0000_0013);

      // single entry, one-cycle latency
      out_ready = 1'b1;
      drive(1'b1, 64'h11, 1'b1);
      tick();
      chk("t1_valid", dn_a.valid, 1'b1);
      chk("t1_data",  dn_a.data,  64'h11);
      chk("t1_ready", up_a.ready, 1'b1);
      drive(1'b0, 64'h0, 1'b0);
      tick();
      chk("t1_drain", dn_a.valid, 1'b0);

      // fill skid, then drain in order
      out_ready = 1'b0;
      drive(1'b1, 64'h1, 1'b1);
      tick();
      drive(1'b1, 64'h2, 1'b1);
      tick();
      chk("t2_full_ready", up_a.ready, 1'b0);
      chk("t2_hold_data",  dn_a.data,  64'h1);
      drive(1'b1, 64'h3, 1'b1);
      tick();
      chk("t2_hold_data2", dn_a.data,  64'h1);
      out_ready = 1'b1;
      tick();
      chk("t2_out2", dn_a.data, 64'h2);
      tick();
      chk("t2_out3", dn_a.data, 64'h3);
      drive(1'b0, 64'h0, 1'b0);
      tick();
      chk("t2_empty", dn_a.valid, 1'b0);

      // flush while full, offered entry must vanish
      out_ready = 1'b0;
      drive(1'b1, 64'hA, 1'b1);
      tick();
      drive(1'b1, 64'hB, 1'b1);
      tick();
      flush = 1'b1;
      drive(1'b1, 64'h99, 1'b1);
      tick();
      flush = 1'b0;
      drive(1'b0, 64'h0, 1'b0);
      chk("t3_valid", dn_a.valid, 1'b0);
      chk("t3_ready", up_a.ready, 1'b1);
      chk("t3_bub_a", dn_a.data,  64'h0);
      chk("t3_bub_b", dn_b.data,  64'h0000_0200_0000_0013);
      out_ready = 1'b1;
      repeat (3) begin
         tick();
         chk("t3_no_99", dn_a.valid, 1'b0);
      end

      // gated lane
      drive(1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b1);
      tick();
      chk("t4_first_b", dn_b.data, 64'hAAAA_BBBB_CCCC_DDDD);
      drive(1'b1, 64'h1111_2222_3333_4444, 1'b0);
      tick();
      chk("t4_gated_b", dn_b.data, 64'h1111_2222_CCCC_DDDD);
      chk("t4_flat_a",  dn_a.data, 64'h1111_2222_3333_4444);
      drive(1'b0, 64'h0, 1'b0);
      tick();

`ifdef YSYX_22050598_PIPE_PERF_EN
      out_ready = 1'b0;
      drive(1'b1, 64'h5, 1'b1);
      tick();
      drive(1'b0, 64'h0, 1'b0);
      repeat (20) tick();
      chk("t5_sat",   stall_b, 4'hF);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t5_flush", stall_b, 4'hF);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_rst",   stall_b, 4'h0);
`endif

      repeat (10000) begin
         in_valid  = ($urandom_range(3) != 0);
         in_data   = {$urandom, $urandom};
         in_gate   = $urandom_range(1);
         out_ready = ($urandom_range(2) != 0);
         flush     = ($urandom_range(31) == 0);
         rst       = ($urandom_range(499) == 0);
         tick();
      end
      rst = 1'b0;
      flush = 1'b0;
      drive(1'b0, 64'h0, 1'b0);
      tick();

      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end
endmodule
